// File: rtl/dftprobe_chain_pkg.sv
// Shared definitions for the probe chain: FSM state encoding, mode
// constants and the width of the scan bit counter.
package dftprobe_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Wide enough to count up to 31, the largest legal channel index.
   localparam int unsigned CNTW = 5;

endpackage

// File: rtl/dftprobe_chain_if.sv
// Probe/test bus of the probe chain.
//   i      : asynchronous probe flags, bit n = channel n
//   ten    : test enable
//   mode   : 0 = direct observe, 1 = capture/scan
//   sel    : channel select for direct observe
//   cap    : capture request (scan mode)
//   tdi_o  : serial/observe data out
//   busy   : scan in progress
//   done   : one-cycle end-of-scan pulse
// master drives the controls, slave is the probe chain.
interface dftprobe_chain_if
   import dftprobe_pkg::*;
#(
   parameter int NCH = 8
);
   localparam int SELW = $clog2(NCH);

   logic [NCH-1:0]  i;
   logic            ten;
   logic            mode;
   logic [SELW-1:0] sel;
   logic            cap;
   logic            tdi_o;
   logic            busy;
   logic            done;

   modport master (
      output i, ten, mode, sel, cap,
      input  tdi_o, busy, done
   );

   modport slave (
      input  i, ten, mode, sel, cap,
      output tdi_o, busy, done
   );

endinterface

// File: rtl/dftprobe_chain_sync.sv
// Single-bit synchroniser, SYNC flops deep, synchronous active-low reset.
//   clk  : block clock
//   rstb : synchronous active-low reset, clears every stage
//   d    : asynchronous input
//   q    : synchronised output (last stage)
module dftprobe_sync
   import dftprobe_pkg::*;
#(
   parameter int SYNC = 2
) (
   input  logic clk,
   input  logic rstb,
   input  logic d,
   output logic q
);

   logic [SYNC-1:0] stage;

   always_ff @(posedge clk) begin
      if (!rstb) begin
         stage <= '0;
      end else begin
         stage <= {stage[SYNC-2:0], d};
      end
   end

   assign q = stage[SYNC-1];

endmodule

// File: rtl/dftprobe_chain.sv
// DFT probe chain: synchronises NCH analog-domain probe flags and either
// presents one selected channel directly on tdi_o, or captures all
// channels and shifts them out LSB first.
//   CELCLK  : block clock, rising edge
//   CELRSTB : synchronous active-low reset
//   CELV/CELG/CELSUB : supply, ground, substrate pins (no logic function)
//   pif     : probe/test bus (slave side)
module dftprobe_chain
   import dftprobe_pkg::*;
#(
   parameter int NCH  = 8,
   parameter int SYNC = 2,
   parameter int SELW = $clog2(NCH)
) (
   input  logic              CELCLK,
   input  logic              CELRSTB,
   input  logic              CELV,
   input  logic              CELG,
   input  logic              CELSUB,
   dftprobe_chain_if.slave   pif
);

   localparam int SELN = 1 << SELW;

   // Supply pins are carried on the port list only.
   logic unused_supply;
   assign unused_supply = ^{CELV, CELG, CELSUB};

   logic [NCH-1:0]  s;
   logic [SELN-1:0] s_ext;

   state_t          state, state_n;
   logic [NCH-1:0]  shreg, shreg_n;
   logic [CNTW-1:0] cnt, cnt_n;
   logic            dir_q, dir_n;

   for (genvar n = 0; n < NCH; n++) begin : g_sync
      dftprobe_sync #(.SYNC(SYNC)) u_sync (
         .clk  (CELCLK),
         .rstb (CELRSTB),
         .d    (pif.i[n]),
         .q    (s[n])
      );
   end

   // Zero-padded to the full select range so sel >= NCH reads 0.
   always_comb begin
      s_ext          = '0;
      s_ext[NCH-1:0] = s;
   end

   always_ff @(posedge CELCLK) begin
      if (!CELRSTB) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
         dir_q <= 1'b0;
      end else begin
         state <= state_n;
         shreg <= shreg_n;
         cnt   <= cnt_n;
         dir_q <= dir_n;
      end
   end

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      cnt_n   = cnt;
      dir_n   = 1'b0;
      if (!pif.ten) begin
         state_n = IDLE;
         shreg_n = '0;
         cnt_n   = '0;
      end else if (pif.mode == MODE_DIRECT) begin
         // Leaving scan mode aborts any scan with no done pulse.
         dir_n   = s_ext[pif.sel];
         state_n = IDLE;
         shreg_n = '0;
         cnt_n   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pif.cap) begin
                  shreg_n = s;
                  cnt_n   = '0;
                  state_n = SHIFT;
               end
            end
            SHIFT: begin
               shreg_n = shreg >> 1;
               cnt_n   = cnt + 1'b1;
               if (cnt == CNTW'(NCH - 1)) begin
                  state_n = DONE;
               end
            end
            DONE: begin
               state_n = IDLE;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   // Outputs decode flops only; dir_q is already 0 outside direct mode.
   assign pif.tdi_o = (state == SHIFT) ? shreg[0] : dir_q;
   assign pif.busy  = (state == SHIFT);
   assign pif.done  = (state == DONE);

endmodule

// File: doc/dftprobe_chain.md
DFTPROBE_CHAIN -- requirements
Module: dftprobe_chain

Interface
REQ-001 Parameter NCH, default 8, number of probe channels; legal range 2..32.
REQ-002 Parameter SYNC, default 2, synchroniser depth per channel; legal range 2..3.
REQ-003 Parameter SELW, default $clog2(NCH), width of the channel select; derived, not overridden.
REQ-004 CELCLK  input  1  single block clock; all state on rising edge.
REQ-005 CELRSTB  input  1  synchronous active-low reset.
REQ-006 CELV  input  1  supply pin; no logic function.
REQ-007 CELG  input  1  ground pin; no logic function.
REQ-008 CELSUB  input  1  substrate pin; no logic function.
REQ-009 i  input  NCH  asynchronous analog-domain probe flags, bit n = channel n.
REQ-010 ten  input  1  test enable; low = block inert.
REQ-011 mode  input  1  0 = direct observe, 1 = capture/scan.
REQ-012 sel  input  SELW  channel select for direct mode.
REQ-013 cap  input  1  capture request, sampled in scan mode only.
REQ-014 tdi_o  output  1  test data out toward the tdi chain.
REQ-015 busy  output  1  high while a scan is in progress.
REQ-016 done  output  1  one-cycle pulse at end of scan.

Function
REQ-017 Each bit of i SHALL pass through SYNC flops before any use; sync vector s[NCH-1:0] is the last stage.
REQ-018 FSM states: IDLE, SHIFT, DONE; 5-bit-wide-enough shift counter cnt and NCH-bit shift register shreg.
REQ-019 ten low: next edge SHALL force state IDLE, shreg=0, cnt=0, tdi_o=0, busy=0, done=0; synchronisers keep running.
REQ-020 Direct mode (ten=1, mode=0): tdi_o SHALL be registered s[sel]; latency from i change to tdi_o = SYNC+1 edges; sel>=NCH gives tdi_o=0.
REQ-021 Scan mode, IDLE, cap=1 at an edge: shreg<=s, cnt<=0, state<=SHIFT, busy<=1 at that edge.
REQ-022 SHIFT: tdi_o SHALL equal shreg[0] (LSB first); each edge shreg shifts right with 0 fill, cnt increments.
REQ-023 SHIFT with cnt=NCH-1 at an edge: state<=DONE; exactly NCH bits are presented, one per cycle.
REQ-024 DONE: done=1, busy=0, tdi_o=0 for one cycle, then IDLE unconditionally.
REQ-025 cap while SHIFT or DONE SHALL be ignored; cap held high in IDLE after DONE starts a new scan.
REQ-026 mode change to 0 during SHIFT/DONE SHALL abort to IDLE on the next edge, no done pulse, busy=0.
REQ-027 Scan mode in IDLE: tdi_o=0, busy=0, done=0.
REQ-028 busy, done, tdi_o SHALL be driven from flops or flop-only decode; no path from i, cap or sel combinationally to outputs.

Reset
REQ-029 CELRSTB low at an edge SHALL clear all synchroniser flops, shreg, cnt, state=IDLE, tdi_o=0, busy=0, done=0.
REQ-030 Reset mid-scan SHALL abort without done pulse; reset has priority over ten, mode and cap.

Structure
REQ-031 Package dftprobe_pkg SHALL hold the FSM state enum and MODE_DIRECT/MODE_SCAN constants.
REQ-032 One sub-module dftprobe_sync (single-bit, SYNC-deep, sync active-low reset) SHALL be instantiated NCH times.
REQ-033 Supply pins SHALL be carried through to the top port list only; no logic connection.

Verification
REQ-034 Reset: CELRSTB=0 for 2 cycles with i=all-ones, ten=1 -> all outputs 0, state IDLE.
REQ-035 Direct: NCH=8, SYNC=2, sel=5, i[5] 0->1 -> tdi_o=1 exactly 3 edges later; sel=7 with i[7]=0 -> tdi_o=0.
REQ-036 Scan: NCH=8, i=8'hA5 steady, one-cycle cap -> busy high 8 cycles, tdi_o = 1,0,1,0,0,1,0,1, then done=1 one cycle, back IDLE.
REQ-037 Abort: mode 1->0 after 3 shifted bits -> IDLE next edge, busy=0, no done; ten=0 mid-scan same result.
REQ-038 Back-to-back: cap held high for 20 cycles, NCH=4 -> two complete scans, cap during SHIFT ignored, done pulses 6 cycles apart.
